// File: rtl/satatx_framer.sv
// SATA link-layer transmit framer: wraps AXI-stream packet words in SOF/EOF,
// fills stalls with HOLD, waits in WTRM, idles on SYNC. Define SATATX_CRC_EN to append CRC-32.
module satatx_framer #(
    parameter logic [32:0] P_SOF        = 33'h1_7cb5_3737,
    parameter logic [32:0] P_EOF        = 33'h1_7cb5_d5d5,
    parameter logic [32:0] P_WTRM       = 33'h1_7cb5_5858,
    parameter logic [32:0] P_SYNC       = 33'h1_7c95_b5b5,
    parameter logic [32:0] P_HOLD       = 33'h1_7caa_d5d5,
    parameter bit          OPT_LOWPOWER = 1'b0
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    input  logic        S_AXIS_TABORT,
    input  logic        i_release,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [32:0] M_AXIS_TDATA,
    output logic        o_busy
);

`ifdef SATATX_CRC_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_DATA, S_EOF, S_WTRM, S_DRAIN, S_CRC
    } state_t;

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_SEED = 32'h5232_5032;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_DATA, S_EOF, S_WTRM, S_DRAIN
    } state_t;
`endif

    state_t      state, state_n;
    logic [32:0] tdata_n;
    logic        abort_q, abort_n;
    logic        step, accept, abort_live, abort;
    logic [31:0] s_word;

    assign step          = !M_AXIS_TVALID || M_AXIS_TREADY;
    // Drain swallows the rest of an aborted packet regardless of sink back-pressure.
    assign S_AXIS_TREADY = ((state == S_DATA) && step) || (state == S_DRAIN);
    assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
    assign o_busy        = (state != S_IDLE);
    assign s_word        = (OPT_LOWPOWER && !(accept && state == S_DATA)) ? 32'h0 : S_AXIS_TDATA;

`ifdef SATATX_CRC_EN
    assign abort_live = (state == S_SOF) || (state == S_DATA) || (state == S_CRC);
`else
    assign abort_live = (state == S_SOF) || (state == S_DATA);
`endif
    // An abort seen while the sink stalls is remembered until the next step.
    assign abort = abort_live && (S_AXIS_TABORT || abort_q);

`ifdef SATATX_CRC_EN
    logic [31:0] crc_q;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ ({32{fb}} & CRC_POLY);
        end
        return r;
    endfunction

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)
            crc_q <= CRC_SEED;
        else if (state == S_SOF)
            crc_q <= CRC_SEED;
        else if (state == S_DATA && accept && !abort)
            crc_q <= crc_step(crc_q, s_word);
    end
`endif

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state         <= S_IDLE;
            abort_q       <= 1'b0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= P_SYNC;
        end else begin
            state        <= state_n;
            abort_q      <= abort_n;
            M_AXIS_TDATA <= tdata_n;
            if (step)
                M_AXIS_TVALID <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        tdata_n = M_AXIS_TDATA;
        abort_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (step) begin
                    tdata_n = P_SYNC;
                    if (S_AXIS_TVALID)
                        state_n = S_SOF;
                end
            end
            S_SOF: begin
                if (!step) begin
                    abort_n = abort;
                end else if (abort) begin
                    tdata_n = P_SYNC;
                    state_n = S_DRAIN;
                end else begin
                    tdata_n = P_SOF;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (!step) begin
                    abort_n = abort;
                end else if (abort) begin
                    // A word accepted alongside the abort is dropped; drain only if TLAST is still ahead.
                    tdata_n = P_SYNC;
                    state_n = (accept && S_AXIS_TLAST) ? S_IDLE : S_DRAIN;
                end else if (S_AXIS_TVALID) begin
                    tdata_n = {1'b0, s_word};
                    if (S_AXIS_TLAST)
`ifdef SATATX_CRC_EN
                        state_n = S_CRC;
`else
                        state_n = S_EOF;
`endif
                end else begin
                    tdata_n = P_HOLD;
                end
            end
`ifdef SATATX_CRC_EN
            S_CRC: begin
                if (!step) begin
                    abort_n = abort;
                end else if (abort) begin
                    tdata_n = P_SYNC;
                    state_n = S_IDLE;
                end else begin
                    tdata_n = {1'b0, crc_q};
                    state_n = S_EOF;
                end
            end
`endif
            S_EOF: begin
                if (step) begin
                    tdata_n = P_EOF;
                    state_n = S_WTRM;
                end
            end
            S_WTRM: begin
                if (i_release) begin
                    state_n = S_IDLE;
                    if (step)
                        tdata_n = P_SYNC;
                end else if (step) begin
                    tdata_n = P_WTRM;
                end
            end
            S_DRAIN: begin
                if (step)
                    tdata_n = P_SYNC;
                if (S_AXIS_TVALID && S_AXIS_TLAST)
                    state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                tdata_n = P_SYNC;
            end
        endcase
    end

endmodule
